// File: rtl/traffic_timer.sv
// traffic_timer: phase interval timer; TS/TL measure ticks elapsed since State_i last changed.
module traffic_timer #(
  parameter int PRESCALE    = 50,
  parameter int SHORT_TICKS = 3,
  parameter int LONG_TICKS  = 10,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] State_i,
  input  logic       En,
  output logic       TS,
  output logic       TL,
  output logic       Tick_o
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] SHORT   = CNT_W'(SHORT_TICKS);
  localparam logic [CNT_W-1:0] LONG    = CNT_W'(LONG_TICKS);
  logic [1:0]       prev_q, prev_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             restart, wrap;
  always_comb begin
    restart = State_i != prev_q;
    wrap    = pre_q == PRE_MAX;
    prev_d  = State_i;
    pre_d   = restart ? '0 : !En ? pre_q : wrap ? '0 : pre_q + 1'b1;
    // a restart on the same edge as a wrap wins, so the new phase starts from zero
    cnt_d   = restart ? '0 : (En && wrap && cnt_q < LONG) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 2'b00;
      pre_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
    end
  end
  assign TS     = cnt_q >= SHORT;
  assign TL     = cnt_q >= LONG;
  assign Tick_o = En & wrap;
endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: directed checks of restart, saturation, enable gating and async reset.
module tb_traffic_timer;
  logic       clk, rst_n, En, TS, TL, Tick_o;
  logic [1:0] State_i;
  int         checks = 0, errors = 0;
  traffic_timer #(.PRESCALE(4), .SHORT_TICKS(3), .LONG_TICKS(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .State_i(State_i), .En(En),
    .TS(TS), .TL(TL), .Tick_o(Tick_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; State_i = 2'd0; En = 1'b1;
    #12;
    chk("rst_ts", TS, 1'b0);
    chk("rst_tl", TL, 1'b0);
    chk("rst_tick", Tick_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    adv(3);  chk("tick_e3", Tick_o, 1'b1);
    adv(8);  chk("ts_e11", TS, 1'b0);
    adv(1);  chk("ts_e12", TS, 1'b1);
    chk("tl_e12", TL, 1'b0);
    adv(7);  chk("tl_e19", TL, 1'b0);
    adv(1);  chk("tl_e20", TL, 1'b1);
    chk("tick_e20", Tick_o, 1'b0);
    adv(3);  chk("tick_e23", Tick_o, 1'b1);
    // saturated and pre==3: this restart coincides with a wrap
    State_i = 2'd1;
    adv(1);  chk("rs_ts", TS, 1'b0);
    chk("rs_tl", TL, 1'b0);
    chk("rs_tick", Tick_o, 1'b0);
    adv(11); chk("rs_ts_e11", TS, 1'b0);
    adv(1);  chk("rs_ts_e12", TS, 1'b1);
    adv(7);  chk("rs_tl_e19", TL, 1'b0);
    adv(1);  chk("rs_tl_e20", TL, 1'b1);
    adv(3);  chk("sat_tick_a", Tick_o, 1'b1);
    adv(1);  chk("sat_tick_b", Tick_o, 1'b0);
    adv(3);  chk("sat_tick_c", Tick_o, 1'b1);
    chk("sat_ts", TS, 1'b1);
    chk("sat_tl", TL, 1'b1);
    adv(2);
    State_i = 2'd2;
    adv(1);  chk("rs2_ts", TS, 1'b0);
    chk("rs2_tl", TL, 1'b0);
    adv(3);  chk("en_tick_pre", Tick_o, 1'b1);
    En = 1'b0;
    #1;      chk("en_tick_off", Tick_o, 1'b0);
    adv(4);  chk("en_gap_tick", Tick_o, 1'b0);
    adv(3);  chk("en_gap_ts", TS, 1'b0);
    En = 1'b1;
    #1;      chk("en_tick_on", Tick_o, 1'b1);
    adv(8);  chk("en_ts_late", TS, 1'b0);
    adv(1);  chk("en_ts_rise", TS, 1'b1);
    En = 1'b0;
    State_i = 2'd3;
    adv(1);  chk("en0_restart", TS, 1'b0);
    En = 1'b1;
    adv(16); chk("ar_ts_pre", TS, 1'b1);
    chk("ar_tl_pre", TL, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("ar_ts_now", TS, 1'b0);
    chk("ar_tick_now", Tick_o, 1'b0);
    #1 rst_n = 1'b1;
    adv(1);
    adv(11); chk("ar_ts_e11", TS, 1'b0);
    adv(1);  chk("ar_ts_e12", TS, 1'b1);
    State_i = 2'd2;
    adv(1);  chk("tog_first", TS, 1'b0);
    for (int i = 0; i < 30; i++) begin
      State_i = State_i ^ 2'd1;
      adv(1);
      chk("tog_ts", TS, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
